// File: rtl/apb4_archinfo_init.sv
// Boot-time APB4 master: writes SYS/IDL/IDH of the archinfo block, reads them back,
// checks the readback and publishes it on sideband outputs.
module apb4_archinfo_init #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] SYS_INIT   = 32'h101F_1010,
  parameter logic [31:0] IDL_INIT   = 32'hFFFF_2022,
  parameter logic [31:0] IDH_INIT   = 32'h00FF_FFFF,
  parameter bit          AUTO_START = 1'b1,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        tmo_o,
  output logic [31:0] sys_o,
  output logic [31:0] idl_o,
  output logic [31:0] idh_o,
  output logic [31:0] paddr,
  output logic [2:0]  pprot,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  wait_q, wait_d;
  logic        first_q, first_d;
  logic        err_q, err_d;
  logic        tmo_q, tmo_d;
  logic [31:0] sys_q, sys_d, idl_q, idl_d, idh_q, idh_d;

  logic        is_write;
  logic [1:0]  reg_sel;
  logic [31:0] init_val;
  logic        bus_active;

  // Steps 0..2 write, 3..5 read the same three registers in order.
  always_comb begin
    is_write = (idx_q < 3'd3);
    reg_sel  = is_write ? idx_q[1:0] : 2'(idx_q - 3'd3);
    case (reg_sel)
      2'd0:    init_val = SYS_INIT;
      2'd1:    init_val = IDL_INIT;
      default: init_val = IDH_INIT;
    endcase
  end

  assign bus_active = (state_q == StSetup) || (state_q == StAccess);

  assign psel    = bus_active;
  assign penable = (state_q == StAccess);
  assign pwrite  = bus_active && is_write;
  assign paddr   = bus_active ? (BASE_ADDR + {28'd0, reg_sel, 2'b00}) : 32'd0;
  assign pwdata  = (bus_active && is_write) ? init_val : 32'd0;
  assign pstrb   = (bus_active && is_write) ? 4'hF : 4'h0;
  assign pprot   = 3'b000;

  assign busy_o = bus_active;
  assign done_o = (state_q == StDone);
  assign err_o  = err_q;
  assign tmo_o  = tmo_q;
  assign sys_o  = sys_q;
  assign idl_o  = idl_q;
  assign idh_o  = idh_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    first_d = 1'b0;  // auto start only honoured in the very first cycle after reset
    err_d   = err_q;
    tmo_d   = tmo_q;
    sys_d   = sys_q;
    idl_d   = idl_q;
    idh_d   = idh_q;

    case (state_q)
      StIdle, StDone: begin
        if (start_i || ((state_q == StIdle) && first_q)) begin
          state_d = StSetup;
          idx_d   = 3'd0;
          err_d   = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      StSetup: begin
        state_d = StAccess;
        wait_d  = 8'd0;
      end
      StAccess: begin
        if (pready) begin
          if (pslverr) begin
            err_d = 1'b1;
          end
          if (!is_write) begin
            case (reg_sel)
              2'd0:    sys_d = prdata;
              2'd1:    idl_d = prdata;
              default: idh_d = prdata;
            endcase
            if (prdata != init_val) begin
              err_d = 1'b1;
            end
          end
          if (idx_q == 3'd5) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StSetup;
          end
        end else if (wait_q == WaitLast) begin
          state_d = StDone;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      wait_q  <= 8'd0;
      first_q <= AUTO_START;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      sys_q   <= 32'd0;
      idl_q   <= 32'd0;
      idh_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      first_q <= first_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      sys_q   <= sys_d;
      idl_q   <= idl_d;
      idh_q   <= idh_d;
    end
  end

endmodule

// File: tb/tb_apb4_archinfo_init.sv
// Bench for apb4_archinfo_init: auto-start instance driven from a vector table against a
// configurable slave model, plus a manual-start instance and a mid-sequence reset.
module tb_apb4_archinfo_init;

  localparam logic [31:0] SYS = 32'h101F_1010;
  localparam logic [31:0] IDL = 32'hFFFF_2022;
  localparam logic [31:0] IDH = 32'h00FF_FFFF;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  // Auto-start instance
  logic        start, busy, done, err, tmo;
  logic [31:0] sys, idl, idh, paddr, pwdata, prdata;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;

  // Manual-start instance
  logic        start_m, busy_m, done_m, err_m, tmo_m;
  logic [31:0] sys_m, idl_m, idh_m, paddr_m, pwdata_m, prdata_m;
  logic [2:0]  pprot_m;
  logic        psel_m, penable_m, pwrite_m, pready_m, pslverr_m;
  logic [3:0]  pstrb_m;

  apb4_archinfo_init #(.AUTO_START(1'b1), .TIMEOUT(16)) dut (
    .pclk(pclk), .presetn(presetn), .start_i(start), .busy_o(busy), .done_o(done),
    .err_o(err), .tmo_o(tmo), .sys_o(sys), .idl_o(idl), .idh_o(idh),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  apb4_archinfo_init #(.AUTO_START(1'b0), .TIMEOUT(16)) dut_m (
    .pclk(pclk), .presetn(presetn), .start_i(start_m), .busy_o(busy_m), .done_o(done_m),
    .err_o(err_m), .tmo_o(tmo_m), .sys_o(sys_m), .idl_o(idl_m), .idh_o(idh_m),
    .paddr(paddr_m), .pprot(pprot_m), .psel(psel_m), .penable(penable_m),
    .pwrite(pwrite_m), .pwdata(pwdata_m), .pstrb(pstrb_m), .prdata(prdata_m),
    .pready(pready_m), .pslverr(pslverr_m)
  );

  int total = 0;
  int bad = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] init_of(input int r);
    case (r)
      0:       return SYS;
      1:       return IDL;
      default: return IDH;
    endcase
  endfunction

  // Slave model configuration for the auto-start instance
  int cfg_waits = 0;
  bit cfg_idl0 = 1'b0;
  bit cfg_hang = 1'b0;
  bit cfg_slverr = 1'b0;

  logic [31:0] mem [4];
  int          acc_cnt;
  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < 4; i++) mem[i] <= 32'd0;
      acc_cnt <= 0;
    end else begin
      if (psel && penable && pready && pwrite) mem[paddr[3:2]] <= pwdata;
      if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
    end
  end

  always_comb begin
    pready  = (acc_cnt >= cfg_waits) && !(cfg_hang && pwrite && (paddr == 32'h4));
    prdata  = 32'd0;
    if (psel && !pwrite) prdata = (cfg_idl0 && (paddr == 32'h4)) ? 32'd0 : mem[paddr[3:2]];
    pslverr = cfg_slverr && psel && penable && !pwrite && (paddr == 32'h8);
  end

  // Zero-wait slave for the manual-start instance
  logic [31:0] mem_m [4];
  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < 4; i++) mem_m[i] <= 32'd0;
    end else if (psel_m && penable_m && pwrite_m) begin
      mem_m[paddr_m[3:2]] <= pwdata_m;
    end
  end
  assign pready_m  = 1'b1;
  assign pslverr_m = 1'b0;
  assign prdata_m  = (psel_m && !pwrite_m) ? mem_m[paddr_m[3:2]] : 32'd0;

  // Scoreboards of expected bus requests
  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] data;
  } xfer_t;
  xfer_t exp_q[$];
  xfer_t exp_mq[$];

  task automatic push_seq(input int n, input bit manual);
    xfer_t x;
    for (int s = 0; s < n; s++) begin
      x.addr  = 32'(4 * (s % 3));
      x.write = (s < 3);
      x.data  = (s < 3) ? init_of(s % 3) : 32'd0;
      if (manual) exp_mq.push_back(x);
      else exp_q.push_back(x);
    end
  endtask

  logic [31:0] hold_addr, hold_data;
  xfer_t       mon_e;
  always @(negedge pclk) begin
    if (presetn && psel) begin
      if (!penable) begin
        hold_addr = paddr;
        hold_data = pwdata;
      end else begin
        check("addr_stable", paddr, hold_addr);
        check("wdata_stable", pwdata, hold_data);
        if (pready) begin
          check("sb_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("paddr", paddr, mon_e.addr);
            check("pwrite", 32'(pwrite), 32'(mon_e.write));
            check("pwdata", pwdata, mon_e.data);
            check("pstrb", 32'(pstrb), mon_e.write ? 32'hF : 32'h0);
            check("pprot", 32'(pprot), 32'd0);
          end
        end
      end
    end
  end

  int    m_cnt = 0;
  int    m_sel_seen = 0;
  xfer_t mon_m;
  always @(negedge pclk) begin
    if (presetn && psel_m) begin
      m_sel_seen++;
      if (penable_m) begin
        m_cnt++;
        check("m_sb_expected", 32'(exp_mq.size() > 0), 32'd1);
        if (exp_mq.size() > 0) begin
          mon_m = exp_mq.pop_front();
          check("m_paddr", paddr_m, mon_m.addr);
          check("m_pwrite", 32'(pwrite_m), 32'(mon_m.write));
          check("m_pwdata", pwdata_m, mon_m.data);
        end
      end
    end
  end

  typedef struct {
    string       name;
    int          waits;
    bit          idl0;
    bit          hang;
    bit          slverr;
    int          done_cyc;
    int          nxfer;
    logic [31:0] sys, idl, idh;
    bit          err, tmo;
  } vec_t;
  vec_t vecs[6];

  task automatic wait_done(input bit manual, input int start_cnt, output int cyc);
    cyc = start_cnt;
    while (cyc < 200 && !(manual ? done_m : done)) begin
      @(posedge pclk);
      #1;
      cyc++;
    end
  endtask

  int cyc;

  initial begin
    vecs[0] = '{"zero_wait", 0, 1'b0, 1'b0, 1'b0, 13, 6, SYS, IDL, IDH, 1'b0, 1'b0};
    vecs[1] = '{"wait3",     3, 1'b0, 1'b0, 1'b0, 31, 6, SYS, IDL, IDH, 1'b0, 1'b0};
    vecs[2] = '{"idl_bad",   0, 1'b1, 1'b0, 1'b0, 13, 6, SYS, 32'd0, IDH, 1'b1, 1'b0};
    vecs[3] = '{"timeout",   0, 1'b0, 1'b1, 1'b0, 20, 1, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1};
    vecs[4] = '{"slverr",    0, 1'b0, 1'b0, 1'b1, 13, 6, SYS, IDL, IDH, 1'b1, 1'b0};
    vecs[5] = '{"wait1",     1, 1'b0, 1'b0, 1'b0, 19, 6, SYS, IDL, IDH, 1'b0, 1'b0};
    start = 1'b0;
    start_m = 1'b0;

    repeat (2) @(posedge pclk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_sys", sys, 32'd0);
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_pwrite", 32'(pwrite), 32'd0);
    check("rst_pstrb", 32'(pstrb), 32'd0);

    for (int v = 0; v < 6; v++) begin
      cfg_waits  = vecs[v].waits;
      cfg_idl0   = vecs[v].idl0;
      cfg_hang   = vecs[v].hang;
      cfg_slverr = vecs[v].slverr;
      exp_q.delete();
      push_seq(vecs[v].nxfer, 1'b0);
      @(negedge pclk);
      presetn = 1'b1;
      wait_done(1'b0, 0, cyc);
      check({vecs[v].name, "_done_cycle"}, 32'(cyc), 32'(vecs[v].done_cyc));
      check({vecs[v].name, "_sys"}, sys, vecs[v].sys);
      check({vecs[v].name, "_idl"}, idl, vecs[v].idl);
      check({vecs[v].name, "_idh"}, idh, vecs[v].idh);
      check({vecs[v].name, "_err"}, 32'(err), 32'(vecs[v].err));
      check({vecs[v].name, "_tmo"}, 32'(tmo), 32'(vecs[v].tmo));
      check({vecs[v].name, "_psel"}, 32'(psel), 32'd0);
      check({vecs[v].name, "_busy"}, 32'(busy), 32'd0);
      check({vecs[v].name, "_left"}, 32'(exp_q.size()), 32'd0);
      @(negedge pclk);
      presetn = 1'b0;
    end

    // Reset asserted during the ACCESS phase of step 4
    cfg_waits = 0; cfg_idl0 = 1'b0; cfg_hang = 1'b0; cfg_slverr = 1'b0;
    exp_q.delete();
    push_seq(6, 1'b0);
    @(negedge pclk);
    presetn = 1'b1;
    repeat (10) @(posedge pclk);
    #1;
    check("mid_penable", 32'(penable), 32'd1);
    check("mid_paddr", paddr, 32'h4);
    check("mid_sys", sys, SYS);
    #2;
    presetn = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_psel", 32'(psel), 32'd0);
    check("mid_rst_paddr", paddr, 32'd0);
    check("mid_rst_sys", sys, 32'd0);
    check("mid_left", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    push_seq(6, 1'b0);
    @(negedge pclk);
    presetn = 1'b1;
    wait_done(1'b0, 0, cyc);
    check("rerun_done_cycle", 32'(cyc), 32'd13);
    check("rerun_idh", idh, IDH);
    check("rerun_err", 32'(err), 32'd0);
    check("rerun_left", 32'(exp_q.size()), 32'd0);

    // Manual-start instance: idle until start_i, ignores start_i while busy
    repeat (20) @(posedge pclk);
    #1;
    check("m_no_activity", 32'(m_sel_seen), 32'd0);
    check("m_idle_done", 32'(done_m), 32'd0);
    push_seq(6, 1'b1);
    start_m = 1'b1;
    @(posedge pclk);
    #1;
    start_m = 1'b0;
    check("m_setup_psel", 32'(psel_m), 32'd1);
    check("m_setup_penable", 32'(penable_m), 32'd0);
    repeat (2) @(posedge pclk);
    #1;
    start_m = 1'b1;
    @(posedge pclk);
    #1;
    start_m = 1'b0;
    wait_done(1'b1, 3, cyc);
    check("m_done_cycle", 32'(cyc), 32'd12);
    check("m_xfers", 32'(m_cnt), 32'd6);
    check("m_sys", sys_m, SYS);
    check("m_idl", idl_m, IDL);
    check("m_err", 32'(err_m), 32'd0);
    check("m_left", 32'(exp_mq.size()), 32'd0);

    // Restart from DONE
    push_seq(6, 1'b1);
    start_m = 1'b1;
    @(posedge pclk);
    #1;
    start_m = 1'b0;
    check("m_restart_done_clr", 32'(done_m), 32'd0);
    check("m_restart_busy", 32'(busy_m), 32'd1);
    wait_done(1'b1, 0, cyc);
    check("m_restart_cycle", 32'(cyc), 32'd12);
    check("m_restart_xfers", 32'(m_cnt), 32'd12);
    check("m_restart_idh", idh_m, IDH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
